// File: rtl/ddr_port_arbiter.sv
// rtl/ddr_port_arbiter.sv - two-port round-robin DDR user-port arbiter with in-order read tag FIFO
// Optional: DDR_ARB_FIXED_PRIO_EN selects fixed priority (port 1 wins ties) instead of round-robin.
module ddr_port_arbiter #(
    parameter int AW       = 28,
    parameter int DW       = 128,
    parameter int LW       = 4,
    parameter int RD_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        s_cmd_valid,
    output logic [1:0]        s_cmd_ready,
    input  logic [1:0]        s_cmd_wr,
    input  logic [2*AW-1:0]   s_cmd_addr,
    input  logic [2*LW-1:0]   s_cmd_len,
    input  logic [2*DW-1:0]   s_wdata,
    input  logic [1:0]        s_wvalid,
    output logic [1:0]        s_wready,
    output logic [DW-1:0]     s_rdata,
    output logic [1:0]        s_rvalid,
    output logic              m_cmd_valid,
    input  logic              m_cmd_ready,
    output logic              m_cmd_wr,
    output logic [AW-1:0]     m_cmd_addr,
    output logic [LW-1:0]     m_cmd_len,
    output logic [DW-1:0]     m_wdata,
    output logic              m_wvalid,
    input  logic              m_wready,
    input  logic [DW-1:0]     m_rdata,
    input  logic              m_rvalid,
    output logic              gnt_owner,
    output logic              rd_orphan_err
);
    localparam int PW = $clog2(RD_DEPTH);

    typedef enum logic [1:0] {IDLE, CMD, WDATA} state_t;

    state_t         state, state_nxt;
    logic           last_grant;
    logic [LW-1:0]  wbeat_cnt;
    logic [LW-1:0]  rbeat_cnt;
    logic [LW:0]    tag_mem [RD_DEPTH];
    logic [PW:0]    wr_ptr, rd_ptr;
    logic           fifo_empty, fifo_full;
    logic [1:0]     eligible;
    logic           pick;
    logic           sel_wr;
    logic [AW-1:0]  sel_addr;
    logic [LW-1:0]  sel_len;
    logic           cmd_fire, wbeat_fire, push, pop, rbeat;
    logic           head_id;
    logic [LW-1:0]  head_len;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = ((wr_ptr - rd_ptr) == (PW+1)'(RD_DEPTH));
    assign head_id    = tag_mem[rd_ptr[PW-1:0]][LW];
    assign head_len   = tag_mem[rd_ptr[PW-1:0]][LW-1:0];

    // A read is only eligible while the tag FIFO has room to remember its owner.
    assign eligible = s_cmd_valid & (s_cmd_wr | {2{~fifo_full}});
`ifdef DDR_ARB_FIXED_PRIO_EN
    assign pick = eligible[1];
`else
    assign pick = (eligible == 2'b11) ? ~last_grant : eligible[1];
`endif

    assign sel_wr   = s_cmd_wr[gnt_owner];
    assign sel_addr = gnt_owner ? s_cmd_addr[AW +: AW] : s_cmd_addr[0 +: AW];
    assign sel_len  = gnt_owner ? s_cmd_len[LW +: LW]  : s_cmd_len[0 +: LW];

    assign cmd_fire   = (state == CMD) && m_cmd_ready;
    assign wbeat_fire = (state == WDATA) && s_wvalid[gnt_owner] && m_wready;
    assign push       = cmd_fire && !sel_wr;
    assign rbeat      = m_rvalid && !fifo_empty;
    assign pop        = rbeat && (rbeat_cnt == head_len);

    always_comb begin
        state_nxt   = state;
        s_cmd_ready = '0;
        m_cmd_valid = 1'b0;
        m_cmd_wr    = 1'b0;
        m_cmd_addr  = '0;
        m_cmd_len   = '0;
        s_wready    = '0;
        m_wvalid    = 1'b0;
        m_wdata     = '0;
        case (state)
            IDLE: begin
                if (|eligible) state_nxt = CMD;
            end
            CMD: begin
                m_cmd_valid            = 1'b1;
                m_cmd_wr               = sel_wr;
                m_cmd_addr             = sel_addr;
                m_cmd_len              = sel_len;
                s_cmd_ready[gnt_owner] = m_cmd_ready;
                if (m_cmd_ready) state_nxt = sel_wr ? WDATA : IDLE;
            end
            WDATA: begin
                m_wvalid            = s_wvalid[gnt_owner];
                m_wdata             = gnt_owner ? s_wdata[DW +: DW] : s_wdata[0 +: DW];
                s_wready[gnt_owner] = m_wready;
                if (wbeat_fire && (wbeat_cnt == '0)) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Read return is steered purely by the FIFO head, independent of the command FSM.
    always_comb begin
        s_rvalid = '0;
        s_rdata  = m_rdata;
        if (rbeat) s_rvalid[head_id] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            gnt_owner     <= 1'b0;
            last_grant    <= 1'b1;
            wbeat_cnt     <= '0;
            rbeat_cnt     <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            rd_orphan_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if ((state == IDLE) && (|eligible)) begin
                gnt_owner  <= pick;
                last_grant <= pick;
            end
            if (cmd_fire && sel_wr) begin
                wbeat_cnt <= sel_len;
            end else if (wbeat_fire) begin
                wbeat_cnt <= wbeat_cnt - 1'b1;
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rbeat_cnt <= '0;
                rd_ptr    <= rd_ptr + 1'b1;
            end else if (rbeat) begin
                rbeat_cnt <= rbeat_cnt + 1'b1;
            end
            if (m_rvalid && fifo_empty) rd_orphan_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) tag_mem[wr_ptr[PW-1:0]] <= {gnt_owner, sel_len};
    end
endmodule

// File: tb/tb_ddr_port_arbiter.sv
// tb/tb_ddr_port_arbiter.sv - scoreboard bench for ddr_port_arbiter
module tb_ddr_port_arbiter;
    localparam int AW = 28;
    localparam int DW = 128;
    localparam int LW = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [1:0]        s_cmd_valid, s_cmd_ready, s_cmd_wr;
    logic [2*AW-1:0]   s_cmd_addr;
    logic [2*LW-1:0]   s_cmd_len;
    logic [2*DW-1:0]   s_wdata;
    logic [1:0]        s_wvalid, s_wready, s_rvalid;
    logic [DW-1:0]     s_rdata, m_wdata, m_rdata;
    logic              m_cmd_valid, m_cmd_ready, m_cmd_wr;
    logic [AW-1:0]     m_cmd_addr;
    logic [LW-1:0]     m_cmd_len;
    logic              m_wvalid, m_wready, m_rvalid;
    logic              gnt_owner, rd_orphan_err;
    logic              any_out;

    int n_cmp = 0;
    int n_err = 0;
    logic          exp_gnt_q[$];
    logic [1:0]    exp_rv_q[$];
    logic [DW-1:0] exp_wd_q[$];

    ddr_port_arbiter #(.AW(AW), .DW(DW), .LW(LW), .RD_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready), .s_cmd_wr(s_cmd_wr),
        .s_cmd_addr(s_cmd_addr), .s_cmd_len(s_cmd_len),
        .s_wdata(s_wdata), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_rdata(s_rdata), .s_rvalid(s_rvalid),
        .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready), .m_cmd_wr(m_cmd_wr),
        .m_cmd_addr(m_cmd_addr), .m_cmd_len(m_cmd_len),
        .m_wdata(m_wdata), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_rdata(m_rdata), .m_rvalid(m_rvalid),
        .gnt_owner(gnt_owner), .rd_orphan_err(rd_orphan_err)
    );

    always #5 clk = ~clk;

    assign any_out = |{s_cmd_ready, s_wready, s_rdata, s_rvalid, m_cmd_valid, m_cmd_wr, m_cmd_addr,
                       m_cmd_len, m_wdata, m_wvalid, gnt_owner, rd_orphan_err};

    task automatic clear_inputs();
        s_cmd_valid = '0; s_cmd_wr = '0; s_cmd_addr = '0; s_cmd_len = '0;
        s_wdata = '0; s_wvalid = '0; m_cmd_ready = 1'b0; m_wready = 1'b0;
        m_rdata = '0; m_rvalid = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic issue_cmd(input int p, input logic wr, input logic [AW-1:0] addr,
                             input logic [LW-1:0] len, output logic ok);
        ok = 1'b0;
        s_cmd_valid[p] = 1'b1; s_cmd_wr[p] = wr;
        s_cmd_addr[p*AW +: AW] = addr; s_cmd_len[p*LW +: LW] = len;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (s_cmd_ready[p]) ok = 1'b1;
            @(posedge clk); #1;
        end
        s_cmd_valid[p] = 1'b0;
    endtask

    task automatic test_reset();
        int beats = 0;
        clear_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (any_out !== 1'b0) begin n_err++; $display("FAIL reset_outputs: any=%b want 0", any_out); end
        @(posedge clk); #1 rst_n = 1'b1;
        s_cmd_valid[1] = 1'b1; s_cmd_wr[1] = 1'b1; s_cmd_addr[AW +: AW] = 28'h100; s_cmd_len[LW +: LW] = 4'd3;
        s_wvalid[1] = 1'b1; s_wdata[DW +: DW] = 128'h55; m_cmd_ready = 1'b1; m_wready = 1'b1;
        for (int i = 0; i < 20 && beats < 2; i++) begin
            @(negedge clk);
            if (s_wready[1]) beats++;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (beats != 2 || m_wvalid !== 1'b1 || gnt_owner !== 1'b1) begin
            n_err++; $display("FAIL reset_midburst_setup: beats=%0d wvalid=%b owner=%b want 2 1 1", beats, m_wvalid, gnt_owner);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (any_out !== 1'b0) begin n_err++; $display("FAIL reset_async_clear: any=%b want 0", any_out); end
        @(negedge clk);
        n_cmp++;
        if (any_out !== 1'b0) begin n_err++; $display("FAIL reset_held: any=%b want 0", any_out); end
        clear_inputs();
        @(posedge clk); #1 rst_n = 1'b1;
        s_cmd_valid[0] = 1'b1; s_cmd_addr[0 +: AW] = 28'h40; s_cmd_len[0 +: LW] = 4'd0; m_cmd_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (m_cmd_valid !== 1'b0 || s_rvalid !== 2'b00) begin
            n_err++; $display("FAIL post_reset_idle: cmd_valid=%b rvalid=%b want 0 00", m_cmd_valid, s_rvalid);
        end
        @(negedge clk);
        n_cmp++;
        if (m_cmd_valid !== 1'b1 || gnt_owner !== 1'b0 || m_cmd_addr !== 28'h40) begin
            n_err++; $display("FAIL post_reset_grant: valid=%b owner=%b addr=%h want 1 0 40", m_cmd_valid, gnt_owner, m_cmd_addr);
        end
        exp_rv_q.push_back(2'b01);
        @(posedge clk); #1 s_cmd_valid[0] = 1'b0; m_rvalid = 1'b1; m_rdata = 128'hA5;
        @(negedge clk);
        n_cmp++;
        if (s_rvalid !== exp_rv_q.pop_front()) begin n_err++; $display("FAIL post_reset_read: rvalid=%b want 01", s_rvalid); end
        @(posedge clk); #1 m_rvalid = 1'b0;
    endtask

    task automatic test_rr_reads();
        int grants = 0;
        logic g;
        logic [1:0] rv;
        logic [DW-1:0] d;
        do_reset();
`ifdef DDR_ARB_FIXED_PRIO_EN
        exp_gnt_q.push_back(1'b1); exp_gnt_q.push_back(1'b0);
        repeat (4) exp_rv_q.push_back(2'b10);
        repeat (4) exp_rv_q.push_back(2'b01);
`else
        exp_gnt_q.push_back(1'b0); exp_gnt_q.push_back(1'b1);
        repeat (4) exp_rv_q.push_back(2'b01);
        repeat (4) exp_rv_q.push_back(2'b10);
`endif
        m_cmd_ready = 1'b1;
        s_cmd_valid = 2'b11; s_cmd_wr = 2'b00;
        s_cmd_addr = {28'h200_0000, 28'h100_0000}; s_cmd_len = {4'd3, 4'd3};
        for (int i = 0; i < 20 && grants < 2; i++) begin
            @(negedge clk);
            if (m_cmd_valid && m_cmd_ready) begin
                g = exp_gnt_q.pop_front();
                grants++;
                n_cmp++;
                if (gnt_owner !== g || s_cmd_ready !== (g ? 2'b10 : 2'b01) ||
                    m_cmd_addr !== (g ? 28'h200_0000 : 28'h100_0000) || m_cmd_wr !== 1'b0) begin
                    n_err++; $display("FAIL rr_grant: owner=%b ready=%b addr=%h want owner %b", gnt_owner, s_cmd_ready, m_cmd_addr, g);
                end
                @(posedge clk); #1 s_cmd_valid[g] = 1'b0;
            end else begin
                @(posedge clk); #1;
            end
        end
        n_cmp++;
        if (grants != 2) begin n_err++; $display("FAIL rr_grant_count: got %0d want 2", grants); end
        for (int b = 0; b < 8; b++) begin
            d = {$urandom(), $urandom(), $urandom(), $urandom()};
            m_rvalid = 1'b1; m_rdata = d;
            @(negedge clk);
            rv = exp_rv_q.pop_front();
            n_cmp++;
            if (s_rvalid !== rv || s_rdata !== d) begin
                n_err++; $display("FAIL rr_read_beat%0d: rvalid=%b data=%h want %b %h", b, s_rvalid, s_rdata, rv, d);
            end
            @(posedge clk); #1;
        end
        m_rvalid = 1'b0;
    endtask

    task automatic test_write_burst();
        logic [DW-1:0] wd [8];
        logic [DW-1:0] d;
        int idx = 0, beats = 0, beats_at_p1 = -1;
        logic acc0, acc1, wbeat;
        for (int k = 0; k < 8; k++) begin
            wd[k] = {$urandom(), $urandom(), $urandom(), 32'(k)};
            exp_wd_q.push_back(wd[k]);
        end
        exp_rv_q.push_back(2'b10);
        s_cmd_valid[0] = 1'b1; s_cmd_wr[0] = 1'b1; s_cmd_addr[0 +: AW] = 28'h300; s_cmd_len[0 +: LW] = 4'd7;
        m_cmd_ready = 1'b1; m_wready = 1'b1;
        for (int i = 0; i < 80 && beats_at_p1 < 0; i++) begin
            s_wvalid[0] = (idx < 8);
            s_wdata[0 +: DW] = (idx < 8) ? wd[idx] : '0;
            @(negedge clk);
            acc0 = m_cmd_valid && m_cmd_ready && !gnt_owner;
            acc1 = m_cmd_valid && m_cmd_ready && gnt_owner;
            wbeat = m_wvalid && m_wready;
            if (acc1) beats_at_p1 = beats;
            if (wbeat) begin
                d = exp_wd_q.pop_front();
                beats++;
                n_cmp++;
                if (m_wdata !== d || s_wready !== 2'b01) begin
                    n_err++; $display("FAIL wr_beat%0d: data=%h wready=%b want %h 01", beats - 1, m_wdata, s_wready, d);
                end
            end
            @(posedge clk); #1;
            if (acc0) begin
                s_cmd_valid[0] = 1'b0;
                s_cmd_valid[1] = 1'b1; s_cmd_wr[1] = 1'b0; s_cmd_addr[AW +: AW] = 28'h400; s_cmd_len[LW +: LW] = 4'd0;
            end
            if (acc1) s_cmd_valid[1] = 1'b0;
            if (wbeat) idx++;
            m_wready = ~m_wready;
        end
        s_wvalid = '0;
        n_cmp++;
        if (beats_at_p1 != 8 || exp_wd_q.size() != 0) begin
            n_err++; $display("FAIL wr_p1_wait: beats before p1 grant=%0d left=%0d want 8 0", beats_at_p1, exp_wd_q.size());
        end
        m_rvalid = 1'b1; m_rdata = 128'h77;
        @(negedge clk);
        n_cmp++;
        if (s_rvalid !== exp_rv_q.pop_front()) begin n_err++; $display("FAIL wr_p1_read: rvalid=%b want 10", s_rvalid); end
        @(posedge clk); #1 m_rvalid = 1'b0;
    endtask

    task automatic test_fifo_full();
        logic ok;
        int nok = 0;
        logic blocked = 1'b1, p1_acc = 1'b0, p1_done = 1'b0, freed = 1'b0, acc, wb;
        m_cmd_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            issue_cmd(0, 1'b0, 28'(28'h500 + k), 4'd1, ok);
            if (ok) nok++;
        end
        n_cmp++;
        if (nok != 4) begin n_err++; $display("FAIL full_fill: accepted %0d want 4", nok); end
        s_cmd_valid = 2'b11; s_cmd_wr = 2'b10; s_cmd_len = {4'd0, 4'd1};
        s_wvalid[1] = 1'b1; s_wdata[DW +: DW] = 128'hBEEF; m_wready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (s_cmd_ready[0]) blocked = 1'b0;
            acc = m_cmd_valid && m_cmd_ready && gnt_owner;
            wb = s_wready[1] && s_wvalid[1];
            if (wb && m_wdata !== 128'hBEEF) begin
                n_err++; $display("FAIL full_write_data: data=%h want beef", m_wdata);
            end
            @(posedge clk); #1;
            if (acc) begin p1_acc = 1'b1; s_cmd_valid[1] = 1'b0; end
            if (wb) begin p1_done = 1'b1; s_wvalid[1] = 1'b0; end
        end
        n_cmp++;
        if (!blocked || !p1_acc || !p1_done) begin
            n_err++; $display("FAIL full_block: blocked=%b write_granted=%b write_done=%b want 1 1 1", blocked, p1_acc, p1_done);
        end
        repeat (2) exp_rv_q.push_back(2'b01);
        for (int b = 0; b < 2; b++) begin
            m_rvalid = 1'b1; m_rdata = 128'(b);
            @(negedge clk);
            n_cmp++;
            if (s_rvalid !== exp_rv_q.pop_front()) begin n_err++; $display("FAIL full_pop_beat%0d: rvalid=%b want 01", b, s_rvalid); end
            @(posedge clk); #1;
        end
        m_rvalid = 1'b0;
        for (int i = 0; i < 6 && !freed; i++) begin
            @(negedge clk);
            if (s_cmd_ready[0]) freed = 1'b1;
            @(posedge clk); #1;
        end
        s_cmd_valid[0] = 1'b0;
        n_cmp++;
        if (!freed) begin n_err++; $display("FAIL full_slot_freed: port0 read granted=%b want 1", freed); end
        repeat (8) exp_rv_q.push_back(2'b01);
        for (int b = 0; b < 8; b++) begin
            m_rvalid = 1'b1; m_rdata = 128'(b + 16);
            @(negedge clk);
            n_cmp++;
            if (s_rvalid !== exp_rv_q.pop_front()) begin n_err++; $display("FAIL full_drain_beat%0d: rvalid=%b want 01", b, s_rvalid); end
            @(posedge clk); #1;
        end
        m_rvalid = 1'b0;
    endtask

    task automatic test_orphan();
        logic ok;
        m_rvalid = 1'b1; m_rdata = 128'hDEAD;
        @(negedge clk);
        n_cmp++;
        if (s_rvalid !== 2'b00) begin n_err++; $display("FAIL orphan_drop: rvalid=%b want 00", s_rvalid); end
        @(posedge clk); #1 m_rvalid = 1'b0;
        n_cmp++;
        if (rd_orphan_err !== 1'b1) begin n_err++; $display("FAIL orphan_set: err=%b want 1", rd_orphan_err); end
        m_cmd_ready = 1'b1;
        issue_cmd(1, 1'b0, 28'h600, 4'd0, ok);
        exp_rv_q.push_back(2'b10);
        m_rvalid = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (!ok || s_rvalid !== exp_rv_q.pop_front() || rd_orphan_err !== 1'b1) begin
            n_err++; $display("FAIL orphan_sticky: ok=%b rvalid=%b err=%b want 1 10 1", ok, s_rvalid, rd_orphan_err);
        end
        @(posedge clk); #1 m_rvalid = 1'b0;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (rd_orphan_err !== 1'b0) begin n_err++; $display("FAIL orphan_cleared: err=%b want 0", rd_orphan_err); end
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic test_fairness();
        int wbeats = 0;
        logic g, cur = 1'b0;
        do_reset();
        for (int k = 0; k < 6; k++) begin
`ifdef DDR_ARB_FIXED_PRIO_EN
            exp_gnt_q.push_back(1'b1);
`else
            exp_gnt_q.push_back(k[0]);
`endif
        end
        s_cmd_valid = 2'b11; s_cmd_wr = 2'b11; s_cmd_len = '0;
        s_cmd_addr = {28'h0B0, 28'h0A0};
        s_wvalid = 2'b11; s_wdata = {128'h1111, 128'h0000};
        m_cmd_ready = 1'b1; m_wready = 1'b1;
        for (int i = 0; i < 40 && wbeats < 6; i++) begin
            @(negedge clk);
            if (m_cmd_valid && m_cmd_ready) begin
                g = exp_gnt_q.pop_front();
                cur = g;
                n_cmp++;
                if (gnt_owner !== g) begin n_err++; $display("FAIL fair_grant: owner=%b want %b", gnt_owner, g); end
            end
            if (m_wvalid && m_wready) begin
                wbeats++;
                n_cmp++;
                if (m_wdata !== (cur ? 128'h1111 : 128'h0000)) begin
                    n_err++; $display("FAIL fair_wdata: data=%h want port %b data", m_wdata, cur);
                end
            end
            @(posedge clk); #1;
        end
        clear_inputs();
        n_cmp++;
        if (wbeats != 6 || exp_gnt_q.size() != 0) begin
            n_err++; $display("FAIL fair_count: beats=%0d grants_left=%0d want 6 0", wbeats, exp_gnt_q.size());
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_rr_reads();
        test_write_burst();
        test_fifo_full();
        test_orphan();
        test_fairness();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
